// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared types and constants for the PC/fetch controller
package pc_pkg;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_EXEC = 2'd2
    } state_e;

    localparam logic [31:0] PC_INC           = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_TRAP_VEC = 32'h0000_0100;

endpackage

// File: rtl/pc_next_sel.sv
// rtl/pc_next_sel.sv - next-PC selection: redirect mux, bit0 clear, alignment trap
module pc_next_sel
    import pc_pkg::*;
#(
    parameter logic [31:0] TRAP_VEC = DEFAULT_TRAP_VEC
) (
    input  logic [31:0] pc_i,
    input  logic        br_taken_i,
    input  logic        jump_i,
    input  logic [31:0] target_i,
    output logic [31:0] pc_plus4_o,
    output logic [31:0] tgt_o,
    output logic [31:0] next_pc_o,
    output logic        trap_o,
    output logic        taken_o
);

    logic redirect;

    always_comb begin
        pc_plus4_o = pc_i + PC_INC;
        tgt_o      = target_i & ~32'h1;
        redirect   = br_taken_i | jump_i;
        trap_o     = 1'b0;
        taken_o    = 1'b0;
        next_pc_o  = pc_plus4_o;
        // A halfword-aligned target is not a legal instruction address here.
        if (redirect) begin
            if (tgt_o[1]) begin
                trap_o    = 1'b1;
                next_pc_o = TRAP_VEC;
            end else begin
                taken_o   = 1'b1;
                next_pc_o = tgt_o;
            end
        end
    end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// rtl/pc_fetch_ctrl.sv - PC register, fetch handshake FSM and held-instruction register
module pc_fetch_ctrl
    import pc_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter logic [31:0] TRAP_VEC = DEFAULT_TRAP_VEC,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             br_taken,
    input  logic             jump,
    input  logic [31:0]      target,
    input  logic             instr_done,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic             imem_gnt,
    input  logic             imem_rvalid,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      instr,
    output logic             instr_valid,
    output logic [31:0]      pc,
    output logic [31:0]      pc_plus4,
    output logic             misalign_exc,
    output logic [31:0]      bad_addr,
    output logic [CNT_W-1:0] taken_cnt
);

    state_e             state_q, state_d;
    logic [31:0]        pc_q, pc_d;
    logic [31:0]        instr_q, instr_d;
    logic               valid_q, valid_d;
    logic               req_q, req_d;
    logic               exc_q, exc_d;
    logic [31:0]        bad_q, bad_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [31:0]        sel_next_pc, sel_tgt;
    logic               sel_trap, sel_taken;

    pc_next_sel #(
        .TRAP_VEC (TRAP_VEC)
    ) u_next_sel (
        .pc_i       (pc_q),
        .br_taken_i (br_taken),
        .jump_i     (jump),
        .target_i   (target),
        .pc_plus4_o (pc_plus4),
        .tgt_o      (sel_tgt),
        .next_pc_o  (sel_next_pc),
        .trap_o     (sel_trap),
        .taken_o    (sel_taken)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        valid_d = valid_q;
        exc_d   = 1'b0;
        bad_d   = bad_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            // req_q gates the grant so nothing is accepted before the request is visible.
            S_REQ: begin
                if (req_q && imem_gnt) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    instr_d = imem_rdata;
                    valid_d = 1'b1;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (instr_done) begin
                    valid_d = 1'b0;
                    pc_d    = sel_next_pc;
                    state_d = S_REQ;
                    exc_d   = sel_trap;
                    if (sel_trap) begin
                        bad_d = sel_tgt;
                    end
                    if (sel_taken) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = S_REQ;
        endcase
        req_d = (state_d == S_REQ);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_REQ;
            pc_q    <= RESET_PC;
            instr_q <= 32'h0;
            valid_q <= 1'b0;
            req_q   <= 1'b0;
            exc_q   <= 1'b0;
            bad_q   <= 32'h0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            req_q   <= req_d;
            exc_q   <= exc_d;
            bad_q   <= bad_d;
            cnt_q   <= cnt_d;
        end
    end

    assign imem_req     = req_q;
    assign imem_addr    = pc_q;
    assign instr        = instr_q;
    assign instr_valid  = valid_q;
    assign pc           = pc_q;
    assign misalign_exc = exc_q;
    assign bad_addr     = bad_q;
    assign taken_cnt    = cnt_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb/tb_pc_fetch_ctrl.sv - self-checking bench for pc_fetch_ctrl
module tb_pc_fetch_ctrl;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] TRAP   = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        br_taken = 1'b0, jump = 1'b0, instr_done = 1'b0;
    logic [31:0] target = 32'h0;
    logic        imem_gnt = 1'b0, imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        imem_req, instr_valid, misalign_exc;
    logic [31:0] imem_addr, instr, pc, pc_plus4, bad_addr, taken_cnt;

    always #5 clk = ~clk;

    pc_fetch_ctrl #(
        .RESET_PC (RST_PC),
        .TRAP_VEC (TRAP),
        .CNT_W    (32)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .br_taken     (br_taken),
        .jump         (jump),
        .target       (target),
        .instr_done   (instr_done),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_gnt     (imem_gnt),
        .imem_rvalid  (imem_rvalid),
        .imem_rdata   (imem_rdata),
        .instr        (instr),
        .instr_valid  (instr_valid),
        .pc           (pc),
        .pc_plus4     (pc_plus4),
        .misalign_exc (misalign_exc),
        .bad_addr     (bad_addr),
        .taken_cnt    (taken_cnt)
    );

    int n_pass = 0;
    int n_total = 0;
    logic [31:0] m_pc, m_bad, m_cnt;

    typedef struct {
        logic        b;
        logic        j;
        logic [31:0] t;
        logic [31:0] e_addr;
        logic        e_trap;
        logic [31:0] e_cnt;
    } vec_t;
    vec_t tbl[10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [31:0] data, input int gdly, input int rdly);
        int w = 0;
        while (!imem_req && w < 20) begin
            cyc();
            w++;
        end
        chk("req_seen", {31'b0, imem_req}, 32'd1);
        chk("imem_addr", imem_addr, m_pc);
        repeat (gdly) begin
            cyc();
            chk("req_hold", {31'b0, imem_req}, 32'd1);
        end
        imem_gnt = 1'b1;
        cyc();
        imem_gnt = 1'b0;
        chk("req_drop", {31'b0, imem_req}, 32'd0);
        chk("exc_pulse_end", {31'b0, misalign_exc}, 32'd0);
        repeat (rdly) cyc();
        imem_rvalid = 1'b1;
        imem_rdata  = data;
        cyc();
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
        chk("instr_valid", {31'b0, instr_valid}, 32'd1);
        chk("instr", instr, data);
        chk("pc", pc, m_pc);
        chk("pc_plus4", pc_plus4, m_pc + 32'd4);
    endtask

    // Reference rules: clear bit0, trap on bit1 of a redirect target, else redirect or step by 4.
    task automatic exec(input logic b, input logic j, input logic [31:0] t, input int dly,
                        output logic trap);
        logic [31:0] tg;
        repeat (dly) begin
            cyc();
            chk("valid_hold", {31'b0, instr_valid}, 32'd1);
        end
        br_taken = b; jump = j; target = t; instr_done = 1'b1;
        cyc();
        instr_done = 1'b0; br_taken = 1'b0; jump = 1'b0; target = $urandom;
        tg   = t & ~32'h1;
        trap = (b | j) && tg[1];
        if (trap) begin
            m_bad = tg;
            m_pc  = TRAP;
        end else if (b | j) begin
            m_pc  = tg;
            m_cnt = m_cnt + 32'd1;
        end else begin
            m_pc  = m_pc + 32'd4;
        end
        chk("misalign_exc", {31'b0, misalign_exc}, {31'b0, trap});
        chk("bad_addr", bad_addr, m_bad);
        chk("taken_cnt", taken_cnt, m_cnt);
        chk("valid_clear", {31'b0, instr_valid}, 32'd0);
        chk("next_addr", imem_addr, m_pc);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic tr;
        logic [31:0] held;
        tbl[0] = '{1'b0, 1'b0, 32'h0000_0123, 32'h0000_0004, 1'b0, 32'd0};
        tbl[1] = '{1'b1, 1'b0, 32'h0000_0040, 32'h0000_0040, 1'b0, 32'd1};
        tbl[2] = '{1'b0, 1'b0, 32'h0000_0007, 32'h0000_0044, 1'b0, 32'd1};
        tbl[3] = '{1'b1, 1'b0, 32'h0000_0200, 32'h0000_0200, 1'b0, 32'd2};
        tbl[4] = '{1'b0, 1'b1, 32'h0000_0301, 32'h0000_0300, 1'b0, 32'd3};
        tbl[5] = '{1'b1, 1'b0, 32'h0000_0206, 32'h0000_0100, 1'b1, 32'd3};
        tbl[6] = '{1'b1, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b0, 32'd4};
        tbl[7] = '{1'b0, 1'b0, 32'h0000_0002, 32'h0000_0000, 1'b0, 32'd4};
        tbl[8] = '{1'b0, 1'b1, 32'h0000_0003, 32'h0000_0100, 1'b1, 32'd4};
        tbl[9] = '{1'b1, 1'b1, 32'h0000_0011, 32'h0000_0010, 1'b0, 32'd5};
        m_pc = RST_PC; m_cnt = 32'd0; m_bad = 32'd0;

        repeat (2) cyc();
        chk("rst_req", {31'b0, imem_req}, 32'd0);
        chk("rst_valid", {31'b0, instr_valid}, 32'd0);
        chk("rst_pc", pc, RST_PC);
        chk("rst_instr", instr, 32'h0);
        chk("rst_cnt", taken_cnt, 32'd0);
        chk("rst_bad", bad_addr, 32'h0);
        chk("rst_exc", {31'b0, misalign_exc}, 32'd0);
        rst_n = 1'b1;
        cyc();
        chk("req_first_edge", {31'b0, imem_req}, 32'd1);
        fetch(32'h0050_0093, 0, 2);

        for (int i = 0; i < 10; i++) begin
            exec(tbl[i].b, tbl[i].j, tbl[i].t, i % 3, tr);
            chk("tbl_addr", imem_addr, tbl[i].e_addr);
            chk("tbl_trap", {31'b0, tr}, {31'b0, tbl[i].e_trap});
            chk("tbl_cnt", taken_cnt, tbl[i].e_cnt);
            if (i == 5) chk("tbl_bad", bad_addr, 32'h0000_0206);
            fetch($urandom, i % 2, (i + 1) % 3);
        end

        for (int i = 0; i < 40; i++) begin
            exec(($urandom % 3) == 0, ($urandom % 4) == 0, $urandom, $urandom_range(0, 2), tr);
            fetch($urandom, $urandom_range(0, 2), $urandom_range(0, 3));
        end

        // Spurious rvalid while executing must not disturb the held instruction.
        held = instr;
        imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        cyc();
        imem_rvalid = 1'b0;
        chk("sp_exec_instr", instr, held);
        chk("sp_exec_valid", {31'b0, instr_valid}, 32'd1);
        chk("sp_exec_req", {31'b0, imem_req}, 32'd0);
        exec(1'b0, 1'b0, 32'h0, 0, tr);
        imem_rvalid = 1'b1;
        cyc();
        imem_rvalid = 1'b0;
        chk("sp_req_req", {31'b0, imem_req}, 32'd1);
        chk("sp_req_addr", imem_addr, m_pc);
        chk("sp_req_valid", {31'b0, instr_valid}, 32'd0);
        imem_gnt = 1'b1;
        cyc();
        imem_gnt = 1'b0;
        br_taken = 1'b1; target = 32'h0000_0500; instr_done = 1'b1;
        cyc();
        br_taken = 1'b0; target = 32'h0; instr_done = 1'b0;
        chk("sp_wait_req", {31'b0, imem_req}, 32'd0);
        chk("sp_wait_valid", {31'b0, instr_valid}, 32'd0);
        chk("sp_wait_cnt", taken_cnt, m_cnt);
        chk("sp_wait_pc", pc, m_pc);
        imem_rvalid = 1'b1; imem_rdata = 32'h1234_5678;
        cyc();
        imem_rvalid = 1'b0;
        chk("sp_wait_instr", instr, 32'h1234_5678);
        chk("sp_wait_valid2", {31'b0, instr_valid}, 32'd1);

        // Reset while a response is outstanding.
        exec(1'b1, 1'b0, 32'h0000_0800, 0, tr);
        imem_gnt = 1'b1;
        cyc();
        imem_gnt = 1'b0;
        cyc();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_pc", pc, RST_PC);
        chk("mid_rst_req", {31'b0, imem_req}, 32'd0);
        chk("mid_rst_cnt", taken_cnt, 32'd0);
        chk("mid_rst_valid", {31'b0, instr_valid}, 32'd0);
        chk("mid_rst_instr", instr, 32'h0);
        cyc();
        rst_n = 1'b1;
        imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_BAD0;
        cyc();
        imem_rvalid = 1'b0;
        chk("late_rv_valid", {31'b0, instr_valid}, 32'd0);
        chk("late_rv_instr", instr, 32'h0);
        chk("late_rv_req", {31'b0, imem_req}, 32'd1);
        m_pc = RST_PC; m_cnt = 32'd0; m_bad = 32'd0;
        fetch(32'h0050_0093, 1, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
